ipm_distributed_fifo_ctrl: RTL and testbench

IPM_DISTRIBUTED_FIFO_CTRL -- requirements
Module: ipm_distributed_fifo_ctrl

---
 rtl/ipm_distributed_fifo_ctrl.sv | 91 +++++++++
 tb/tb_ipm_distributed_fifo_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ipm_distributed_fifo_ctrl.sv
// Pointer and flag controller for a FIFO built on an external simple dual-port RAM.
// Read side is first-word-fall-through: the RAM read address always points at the head word.
module ipm_distributed_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH       = 4,
  parameter int unsigned ALMOST_FULL_NUM  = 2**ADDR_WIDTH - 2,
  parameter int unsigned ALMOST_EMPTY_NUM = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   water_level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] AfNum = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AeNum = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] level_d;
  logic                wr_acc, rd_acc;
  logic                full_d, empty_d, almost_full_d, almost_empty_d;
  logic                overflow_d, underflow_d;

  // Acceptance uses the registered flags, so a read never frees space for a same-cycle write.
  assign wr_acc    = wr_en && !full && !flush;
  assign rd_acc    = rd_en && !empty && !flush;
  assign ram_wr_en = wr_acc;

  assign ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
      if (rd_acc) rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
  end

  // Flags come from next-state pointers so they are exact right after the edge.
  always_comb begin
    level_d        = wr_ptr_d - rd_ptr_d;
    full_d         = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
    empty_d        = (wr_ptr_d == rd_ptr_d);
    almost_full_d  = (level_d >= AfNum);
    almost_empty_d = (level_d <= AeNum);
    overflow_d     = wr_en && full && !flush;
    underflow_d    = rd_en && empty && !flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      water_level  <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      water_level  <= level_d;
      full         <= full_d;
      empty        <= empty_d;
      almost_full  <= almost_full_d;
      almost_empty <= almost_empty_d;
      overflow     <= overflow_d;
      underflow    <= underflow_d;
    end
  end

endmodule

// File: tb/tb_ipm_distributed_fifo_ctrl.sv
// Directed bench for ipm_distributed_fifo_ctrl (ADDR_WIDTH=4, default thresholds 14/2).
module tb_ipm_distributed_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, wr_en, rd_en;
  logic       ram_wr_en;
  logic [3:0] ram_wr_addr, ram_rd_addr;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] water_level;

  int n_total = 0;
  int n_pass  = 0;

  ipm_distributed_fifo_ctrl #(.ADDR_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_rd_addr  (ram_rd_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .water_level  (water_level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr, rd, fl;
    logic       rwe;
    logic [3:0] wa, ra;
    logic [4:0] lvl;
    logic       fu, em, af, ae, ov, un;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic apply(input logic w, input logic r, input logic f);
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    flush = f;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [17:0] state_now();
    return {ram_wr_addr, ram_rd_addr, water_level, full, empty, almost_full, almost_empty,
            overflow};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 4'd1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd2, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    #2;
    chk("reset state", {state_now(), underflow}, {4'd0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1,
                                                  1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    // Table: underflow, basic writes/reads, simultaneous access, flush priority.
    for (int i = 0; i < 12; i++) begin
      apply(vt[i].wr, vt[i].rd, vt[i].fl);
      chk($sformatf("v%0d ram_wr_en", i), 32'(ram_wr_en), 32'(vt[i].rwe));
      step();
      chk($sformatf("v%0d state", i), {state_now(), underflow},
          {vt[i].wa, vt[i].ra, vt[i].lvl, vt[i].fu, vt[i].em, vt[i].af, vt[i].ae, vt[i].ov,
           vt[i].un});
    end

    // Fill from reset: addresses 0..15, almost_full after 14th, full after 16th.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      chk($sformatf("fill%0d addr", i), 32'(ram_wr_addr), 32'(i));
      chk($sformatf("fill%0d wen", i), 32'(ram_wr_en), 32'd1);
      step();
      chk($sformatf("fill%0d flags", i), {water_level, almost_full, full, empty},
          {5'(i + 1), (i >= 13), (i == 15), 1'b0});
    end
    // Overflow: write rejected while full, one pulse, pointers hold.
    apply(1'b1, 1'b0, 1'b0);
    chk("ovf wen", 32'(ram_wr_en), 32'd0);
    step();
    chk("ovf pulse", {overflow, ram_wr_addr, ram_rd_addr, water_level, full},
        {1'b1, 4'd0, 4'd0, 5'd16, 1'b1});
    apply(1'b1, 1'b1, 1'b0);
    chk("full wr+rd wen", 32'(ram_wr_en), 32'd0);
    step();
    chk("full wr+rd", {overflow, water_level, full, ram_rd_addr}, {1'b1, 5'd15, 1'b0, 4'd1});
    apply(1'b0, 1'b0, 1'b0);
    step();
    chk("ovf cleared", 32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) begin
      apply(1'b0, 1'b1, 1'b0);
      chk($sformatf("drain%0d addr", i), 32'(ram_rd_addr), 32'(i));
      step();
    end
    chk("drained", {empty, water_level, ram_wr_addr, ram_rd_addr, underflow},
        {1'b1, 5'd0, 4'd0, 4'd0, 1'b0});

    // Level 5 then 20 cycles of simultaneous read/write across the address wrap.
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 1'b1, 1'b0);
      step();
      chk($sformatf("sim%0d", i),
          {water_level, full, empty, almost_full, almost_empty, ram_wr_addr, ram_rd_addr},
          {5'd5, 4'b0000, 4'((5 + i + 1) % 16), 4'((i + 1) % 16)});
    end

    // Flush at level 9 with wr and rd asserted.
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      step();
    end
    chk("pre-flush level", 32'(water_level), 32'd9);
    apply(1'b1, 1'b1, 1'b1);
    chk("flush wen", 32'(ram_wr_en), 32'd0);
    step();
    chk("flush", {water_level, empty, almost_empty, overflow, underflow, ram_wr_addr, ram_rd_addr},
        {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0});

    // Async reset between edges at level 7.
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      step();
    end
    apply(1'b0, 1'b0, 1'b0);
    chk("pre-rst level", 32'(water_level), 32'd7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst", {state_now(), underflow}, {4'd0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1,
                                                1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    apply(1'b1, 1'b0, 1'b0);
    chk("post-rst addr", {ram_wr_en, ram_wr_addr}, {1'b1, 4'd0});
    step();
    chk("post-rst level", 32'(water_level), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
